// File: rtl/chip_mux_checker.sv
// chip_mux_checker: exhaustive vector tester for N:1 multiplexer chips with result latching.
module chip_mux_checker #(
  parameter int SEL_W = 2,
  parameter int CHANNELS = 2,
  parameter int SETTLE = 2,
  parameter int STROBE_ACTIVE_LOW = 1,
  parameter int INVERT_OUT = 0,
  parameter int ERR_W = 16,
  localparam int N = 2**SEL_W,
  localparam int VW = CHANNELS + SEL_W + N
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Run,
  input  logic                  DISP_RSLT,
  input  logic [CHANNELS-1:0]   Y_in,
  output logic [SEL_W-1:0]      Sel_out,
  output logic [CHANNELS*N-1:0] Data_out,
  output logic [CHANNELS-1:0]   Strobe_out,
  output logic                  Busy,
  output logic                  Done,
  output logic                  RSLT,
  output logic [ERR_W-1:0]      Err_count,
  output logic [VW-1:0]         Fail_vec,
  output logic [CHANNELS-1:0]   Fail_mask
);
  localparam int CW = $clog2(SETTLE) + 1;
  localparam int PW = $clog2(CHANNELS + 1);
  localparam logic SAL = 1'(STROBE_ACTIVE_LOW);
  localparam logic INV = 1'(INVERT_OUT);
  typedef enum logic [2:0] {ST_HALT, ST_SET, ST_DRIVE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
  state_t state_q, state_d;
  logic [VW-1:0] v_q, v_d, fvec_q, fvec_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic rslt_q, rslt_d;
  logic [CHANNELS-1:0] fmask_q, fmask_d, exp_v, mis;
  logic [SEL_W-1:0] sel_q;
  logic [CHANNELS*N-1:0] data_q, dq;
  logic [CHANNELS-1:0] stb_q;
  logic [PW-1:0] pop;
  logic [ERR_W:0] sum;
  // Channel c sees D rotated left by c so a short between channels shows up as a mismatch.
  function automatic logic [CHANNELS*N-1:0] rot(input logic [N-1:0] d);
    rot = '0;
    for (int c = 0; c < CHANNELS; c++)
      for (int i = 0; i < N; i++)
        rot[c*N+i] = d[(i + N - c % N) % N];
  endfunction
  always_comb begin
    dq = rot(v_q[N-1:0]);
    pop = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      exp_v[c] = (v_q[VW-CHANNELS+c] & dq[c*N + int'(v_q[SEL_W+N-1 -: SEL_W])]) ^ INV;
      mis[c] = exp_v[c] ^ Y_in[c];
      pop = pop + PW'(mis[c]);
    end
    sum = {1'b0, err_q} + (ERR_W+1)'(pop);
  end
  always_comb begin
    state_d = state_q;
    v_d = v_q;
    cnt_d = cnt_q;
    err_d = err_q;
    rslt_d = rslt_q;
    fvec_d = fvec_q;
    fmask_d = fmask_q;
    case (state_q)
      ST_HALT: state_d = Run ? ST_SET : ST_HALT;
      ST_SET: state_d = ST_DRIVE;
      ST_DRIVE: begin
        state_d = ST_SETTLE;
        cnt_d = '0;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(SETTLE - 1)) ? ST_SAMPLE : ST_SETTLE;
      end
      ST_SAMPLE: begin
        state_d = &v_q ? ST_DONE : ST_DRIVE;
        v_d = &v_q ? v_q : v_q + 1'b1;
        if (|mis) begin
          rslt_d = 1'b0;
          err_d = sum[ERR_W] ? '1 : sum[ERR_W-1:0];
          fvec_d = rslt_q ? v_q : fvec_q;
          fmask_d = rslt_q ? mis : fmask_q;
        end
      end
      ST_DONE: state_d = DISP_RSLT ? ST_HALT : ST_DONE;
      default: state_d = ST_HALT;
    endcase
    if (state_d == ST_SET) begin
      v_d = '0;
      err_d = '0;
      fvec_d = '0;
      fmask_d = '0;
      rslt_d = 1'b1;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_HALT;
      v_q <= '0;
      cnt_q <= '0;
      err_q <= '0;
      rslt_q <= 1'b0;
      fvec_q <= '0;
      fmask_q <= '0;
      sel_q <= '0;
      data_q <= '0;
      stb_q <= {CHANNELS{SAL}};
    end else begin
      state_q <= state_d;
      v_q <= v_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      rslt_q <= rslt_d;
      fvec_q <= fvec_d;
      fmask_q <= fmask_d;
      if (state_d == ST_DRIVE) begin
        sel_q <= v_d[SEL_W+N-1 -: SEL_W];
        data_q <= rot(v_d[N-1:0]);
        stb_q <= v_d[VW-1 -: CHANNELS] ^ {CHANNELS{SAL}};
      end else if (state_d != ST_SETTLE && state_d != ST_SAMPLE) begin
        sel_q <= '0;
        data_q <= '0;
        stb_q <= {CHANNELS{SAL}};
      end
    end
  end
  assign Sel_out = sel_q;
  assign Data_out = data_q;
  assign Strobe_out = stb_q;
  assign Busy = state_q inside {ST_SET, ST_DRIVE, ST_SETTLE, ST_SAMPLE};
  assign Done = state_q == ST_DONE;
  assign RSLT = rslt_q;
  assign Err_count = err_q;
  assign Fail_vec = fvec_q;
  assign Fail_mask = fmask_q;
endmodule

// File: tb/tb_chip_mux_checker.sv
// tb_chip_mux_checker: directed checks of the mux tester against ideal and faulty chip models.
module tb_chip_mux_checker;
  logic clk = 1'b0, rst, run_ab, run_c, disp, fault;
  int checks = 0, errors = 0, cyc;
  always #5 clk = ~clk;
  logic [1:0] sel_a, sel_b, stb_a, stb_b, ya, yb, fm_a, fm_b;
  logic [7:0] data_a, data_b, fv_a, fv_b, data_c;
  logic busy_a, done_a, rslt_a, busy_b, done_b, rslt_b;
  logic [15:0] err_a;
  logic [3:0] err_b;
  logic [2:0] sel_c;
  logic stb_c, yc, busy_c, done_c, rslt_c, fm_c;
  logic [15:0] err_c;
  logic [11:0] fv_c;
  // Ideal 74153 model driven from the pins; fault forces section 1 output low.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      ya[c] = ~stb_a[c] & data_a[c*4 + int'(sel_a)];
      yb[c] = ~stb_b[c] & data_b[c*4 + int'(sel_b)];
    end
    ya[1] = ya[1] & ~fault;
    yb[1] = 1'b0;
    yc = ~(~stb_c & data_c[sel_c]);
  end
  chip_mux_checker dut_a (.Clk(clk), .Reset(rst), .Run(run_ab), .DISP_RSLT(disp), .Y_in(ya),
    .Sel_out(sel_a), .Data_out(data_a), .Strobe_out(stb_a), .Busy(busy_a), .Done(done_a),
    .RSLT(rslt_a), .Err_count(err_a), .Fail_vec(fv_a), .Fail_mask(fm_a));
  chip_mux_checker #(.ERR_W(4)) dut_b (.Clk(clk), .Reset(rst), .Run(run_ab), .DISP_RSLT(disp),
    .Y_in(yb), .Sel_out(sel_b), .Data_out(data_b), .Strobe_out(stb_b), .Busy(busy_b),
    .Done(done_b), .RSLT(rslt_b), .Err_count(err_b), .Fail_vec(fv_b), .Fail_mask(fm_b));
  chip_mux_checker #(.SEL_W(3), .CHANNELS(1), .INVERT_OUT(1)) dut_c (.Clk(clk), .Reset(rst),
    .Run(run_c), .DISP_RSLT(disp), .Y_in(yc), .Sel_out(sel_c), .Data_out(data_c),
    .Strobe_out(stb_c), .Busy(busy_c), .Done(done_c), .RSLT(rslt_c), .Err_count(err_c),
    .Fail_vec(fv_c), .Fail_mask(fm_c));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    rst = 1'b1; run_ab = 1'b0; run_c = 1'b0; disp = 1'b0; fault = 1'b0;
    step(3);
    chk("rst_busy", busy_a, 0); chk("rst_done", done_a, 0); chk("rst_rslt", rslt_a, 0);
    chk("rst_err", err_a, 0); chk("rst_fvec", fv_a, 0); chk("rst_fmask", fm_a, 0);
    chk("rst_sel", sel_a, 0); chk("rst_data", data_a, 0); chk("rst_stb", stb_a, 2'b11);
    rst = 1'b0; step(1);
    chk("idle_busy", busy_a, 0);
    run_ab = 1'b1; step(1); run_ab = 1'b0;
    chk("t1_set_busy", busy_a, 1); chk("t1_set_rslt", rslt_a, 1);
    cyc = 0;
    while (!done_a && cyc < 3000) begin step(1); cyc++; end
    chk("t1_cycles", cyc, 1025);
    chk("t1_rslt", rslt_a, 1); chk("t1_err", err_a, 0); chk("t1_fmask", fm_a, 0);
    chk("t1_busy", busy_a, 0);
    chk("b_done", done_b, 1); chk("b_rslt", rslt_b, 0); chk("b_err_sat", err_b, 15);
    chk("b_fvec", fv_b, 8'h88); chk("b_fmask", fm_b, 2'b10);
    step(10);
    chk("t1_hold_done", done_a, 1); chk("t1_hold_rslt", rslt_a, 1);
    disp = 1'b1; step(1); disp = 1'b0;
    chk("t1_ack_done", done_a, 0); chk("t1_ack_busy", busy_a, 0);
    step(1);
    fault = 1'b1;
    run_ab = 1'b1; step(1); run_ab = 1'b0;
    cyc = 0;
    while (!done_a && cyc < 3000) begin step(1); cyc++; end
    chk("t2_cycles", cyc, 1025);
    chk("t2_rslt", rslt_a, 0); chk("t2_err", err_a, 64);
    chk("t2_fvec", fv_a, 8'h88); chk("t2_fmask", fm_a, 2'b10);
    step(10);
    chk("t2_hold_done", done_a, 1); chk("t2_hold_err", err_a, 64);
    chk("t2_hold_fvec", fv_a, 8'h88); chk("t2_hold_fmask", fm_a, 2'b10);
    disp = 1'b1; run_ab = 1'b1; step(1); disp = 1'b0;
    chk("rs_halt_done", done_a, 0); chk("rs_halt_busy", busy_a, 0);
    step(1); run_ab = 1'b0;
    chk("rs_set_busy", busy_a, 1); chk("rs_set_err", err_a, 0);
    chk("rs_set_rslt", rslt_a, 1); chk("rs_set_fvec", fv_a, 0);
    step(258);
    chk("v40_busy", busy_a, 1); chk("v40_stb", stb_a, 2'b10);
    chk("v40_sel", sel_a, 0); chk("v40_data", data_a, 0);
    rst = 1'b1; step(1);
    chk("mid_rst_busy", busy_a, 0); chk("mid_rst_stb", stb_a, 2'b11);
    chk("mid_rst_data", data_a, 0); chk("mid_rst_rslt", rslt_a, 0);
    chk("mid_rst_done", done_a, 0);
    rst = 1'b0; step(1);
    chk("post_rst_halt", busy_a, 0);
    run_ab = 1'b1; step(1); run_ab = 1'b0;
    chk("rerun_busy", busy_a, 1);
    step(5);
    chk("rerun_v1_data", data_a, 8'h21); chk("rerun_v1_stb", stb_a, 2'b11);
    chk("rerun_v1_sel", sel_a, 0);
    rst = 1'b1; step(1); rst = 1'b0; step(1);
    run_c = 1'b1; step(1); run_c = 1'b0;
    chk("c_set_busy", busy_c, 1);
    cyc = 0;
    while (!done_c && cyc < 20000) begin step(1); cyc++; end
    chk("c_cycles", cyc, 16385);
    chk("c_rslt", rslt_c, 1); chk("c_err", err_c, 0); chk("c_fmask", fm_c, 0);
    disp = 1'b1; step(1); disp = 1'b0;
    chk("c_ack", done_c, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
